thread_scheduler: RTL and testbench

//  Fine-grained barrel-thread scheduler for the 4-thread pipeline sharing the 64-entry banked register file.

---
 rtl/thread_pkg.sv | 15 +
 rtl/rr_pick.sv | 27 ++
 rtl/thread_scheduler.sv | 110 +++++++++++
 tb/tb_thread_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_pkg.sv
// Shared thread definitions used by the register file, fetch and the scheduler.
package thread_pkg;

  localparam int NUM_THREADS = 4;
  localparam int TID_W       = $clog2(NUM_THREADS);

  typedef logic [TID_W-1:0] tid_t;

  // One pipeline slot: whether it carries a real thread, and which one.
  typedef struct packed {
    logic valid;
    tid_t tid;
  } slot_t;

endpackage : thread_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requesting thread after 'last'.
module rr_pick
  import thread_pkg::*;
(
  input  logic [NUM_THREADS-1:0] req,
  input  tid_t                   last,
  output logic                   gnt_valid,
  output tid_t                   gnt_tid
);

  logic [2*NUM_THREADS-1:0] dbl;

  // Doubled-vector scan; walking offsets downward lets the nearest requester win.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    dbl       = {req, req};
    gnt_valid = 1'b0;
    gnt_tid   = '0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      if (dbl[int'(last) + i]) begin
        gnt_valid = 1'b1;
        gnt_tid   = tid_t'((int'(last) + i) % NUM_THREADS);
      end
    end
  end

endmodule : rr_pick

// File: rtl/thread_scheduler.sv
// Barrel-thread scheduler: round-robin issue of runnable threads and a
// WB_LAT-deep slot pipeline that delivers the writeback thread ID.
module thread_scheduler
  import thread_pkg::*;
#(
  parameter int WB_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] thread_start,
  input  logic                   halt_valid,
  input  tid_t                   halt_tid,
  input  logic                   stall,
  output logic                   issue_valid,
  output tid_t                   issue_tid,
  output logic                   wb_valid,
  output tid_t                   wb_tid,
  output logic [NUM_THREADS-1:0] active_mask,
  output logic                   all_idle
);

  logic [NUM_THREADS-1:0] active_q, active_d;
  logic [NUM_THREADS-1:0] halt_oh, nmask;
  tid_t                   last_tid_q, last_tid_d;
  slot_t                  issue_q, issue_d;
  slot_t                  slot_w [WB_LAT];
  slot_t                  slot_d [WB_LAT];
  logic                   gnt_valid;
  tid_t                   gnt_tid;
  logic                   any_slot;

  // Runnable set for this edge: starts added, a halt removes its thread and wins over a start.
  always_comb begin
    halt_oh = '0;
    if (halt_valid && (int'(halt_tid) < NUM_THREADS)) halt_oh[halt_tid] = 1'b1;
    nmask = (active_q | thread_start) & ~halt_oh;
  end

  rr_pick u_pick (
    .req       (nmask),
    .last      (last_tid_q),
    .gnt_valid (gnt_valid),
    .gnt_tid   (gnt_tid)
  );

  // Next issue slot and round-robin pointer; a stall freezes both but never the mask.
  always_comb begin
    active_d   = nmask;
    issue_d    = issue_q;
    last_tid_d = last_tid_q;
    if (!stall) begin
      if (gnt_valid) begin
        issue_d    = '{valid: 1'b1, tid: gnt_tid};
        last_tid_d = gnt_tid;
      end else begin
        issue_d.valid = 1'b0;
      end
    end
  end

  // Mask, pointer and issue registers; pointer resets to the last thread so thread 0 goes first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q   <= '0;
      last_tid_q <= tid_t'(NUM_THREADS - 1);
      issue_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      active_q   <= active_d;
      last_tid_q <= last_tid_d;
      issue_q    <= issue_d;
    end
  end

  // Slot shift: stage 0 takes the issue slot, later stages take their predecessor; stall holds all.
  always_comb begin
    slot_d[0] = stall ? slot_w[0] : issue_q;
    for (int i = 1; i < WB_LAT; i++) begin
      slot_d[i] = stall ? slot_w[i] : slot_w[i-1];
    end
  end

  for (genvar g = 0; g < WB_LAT; g++) begin : g_slot
    slot_t stage_q;

    // One slot-pipeline stage; reset discards whatever was in flight.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) stage_q <= '0;
      else       stage_q <= slot_d[g];
    end

    assign slot_w[g] = stage_q;
  end

  // Idle only when nothing is runnable and no real thread remains anywhere in the pipeline.
  always_comb begin
    any_slot = issue_q.valid;
    for (int i = 0; i < WB_LAT; i++) begin
      any_slot = any_slot | slot_w[i].valid;
    end
    all_idle = (active_q == '0) && !any_slot;
  end

  assign issue_valid = issue_q.valid;
  assign issue_tid   = issue_q.tid;
  assign wb_valid    = slot_w[WB_LAT-1].valid;
  assign wb_tid      = slot_w[WB_LAT-1].tid;
  assign active_mask = active_q;

endmodule : thread_scheduler

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed scenarios plus a random
// run, all compared against a behavioural model of the scheduling rules.
module tb_thread_scheduler;
  import thread_pkg::*;

  localparam int WB_LAT = 3;
  localparam int N      = NUM_THREADS;

  logic         clk;
  logic         reset;
  logic [N-1:0] thread_start;
  logic         halt_valid;
  tid_t         halt_tid;
  logic         stall;
  logic         issue_valid;
  tid_t         issue_tid;
  logic         wb_valid;
  tid_t         wb_tid;
  logic [N-1:0] active_mask;
  logic         all_idle;

  int errors = 0;
  int checks = 0;

  // Reference model state: runnable set, last picked thread, issue slot, in-flight queue.
  logic [N-1:0] m_mask;
  int           m_last;
  bit           m_iv;
  int           m_it;
  bit           pv[$];
  int           pt[$];

  thread_scheduler #(.WB_LAT(WB_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .thread_start (thread_start),
    .halt_valid   (halt_valid),
    .halt_tid     (halt_tid),
    .stall        (stall),
    .issue_valid  (issue_valid),
    .issue_tid    (issue_tid),
    .wb_valid     (wb_valid),
    .wb_tid       (wb_tid),
    .active_mask  (active_mask),
    .all_idle     (all_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = '0;
    m_last = N - 1;
    m_iv   = 1'b0;
    m_it   = 0;
    pv.delete();
    pt.delete();
    for (int i = 0; i < WB_LAT; i++) begin
      pv.push_back(1'b0);
      pt.push_back(0);
    end
  endtask

  // Apply the scheduling rules for one clock edge.
  task automatic model_edge(input logic [N-1:0] st, input bit hv, input int ht, input bit sl);
    logic [N-1:0] nm;
    bit           found;
    int           p;
    nm = (m_mask | st) & ~(hv ? (N'(1) << ht) : N'(0));
    if (!sl) begin
      pv.push_front(m_iv);
      pt.push_front(m_it);
      void'(pv.pop_back());
      void'(pt.pop_back());
      found = 1'b0;
      p     = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && nm[(m_last + k) % N]) begin
          found = 1'b1;
          p     = (m_last + k) % N;
        end
      end
      if (found) begin
        m_iv   = 1'b1;
        m_it   = p;
        m_last = p;
      end else begin
        m_iv = 1'b0;
      end
    end
    m_mask = nm;
  endtask

  task automatic check_all(input string tag);
    bit busy;
    busy = m_iv;
    foreach (pv[i]) busy |= pv[i];
    check({tag, " issue_valid"}, 32'(issue_valid), 32'(m_iv));
    check({tag, " issue_tid"},   32'(issue_tid),   32'(m_it));
    check({tag, " wb_valid"},    32'(wb_valid),    32'(pv[WB_LAT-1]));
    check({tag, " wb_tid"},      32'(wb_tid),      32'(pt[WB_LAT-1]));
    check({tag, " active_mask"}, 32'(active_mask), 32'(m_mask));
    check({tag, " all_idle"},    32'(all_idle),    32'((m_mask == '0) && !busy));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input string tag, input logic [N-1:0] st, input bit hv, input int ht, input bit sl);
    thread_start = st;
    halt_valid   = hv;
    halt_tid     = tid_t'(ht);
    stall        = sl;
    model_edge(st, hv, ht, sl);
    @(posedge clk);
    #1;
    thread_start = '0;
    halt_valid   = 1'b0;
    halt_tid     = '0;
    stall        = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
  endtask

  initial begin
    int seq1[6];
    int seq2[6];
    reset        = 1'b1;
    thread_start = '0;
    halt_valid   = 1'b0;
    halt_tid     = '0;
    stall        = 1'b0;
    model_reset();

    // 1: all four threads start, strict rotation from thread 0.
    do_reset();
    seq1 = '{0, 1, 2, 3, 0, 1};
    step("t1", 4'b1111, 0, 0, 0);
    check("t1 first", 32'(issue_tid), 32'(seq1[0]));
    for (int i = 1; i < 6; i++) begin
      step("t1", '0, 0, 0, 0);
      check("t1 seq", 32'(issue_tid), 32'(seq1[i]));
    end
    check("t1 valid", 32'(issue_valid), 32'd1);

    // 2: threads 0 and 2 alternate; adding thread 1 joins the rotation after the next pick.
    do_reset();
    step("t2", 4'b0101, 0, 0, 0);
    check("t2 first", 32'(issue_tid), 32'd0);
    step("t2", '0, 0, 0, 0);
    check("t2 second", 32'(issue_tid), 32'd2);
    step("t2", '0, 0, 0, 0);
    step("t2", '0, 0, 0, 0);
    check("t2 fourth", 32'(issue_tid), 32'd2);
    seq2 = '{0, 1, 2, 0, 1, 2};
    step("t2", 4'b0010, 0, 0, 0);
    check("t2 join", 32'(issue_tid), 32'(seq2[0]));
    for (int i = 1; i < 6; i++) begin
      step("t2", '0, 0, 0, 0);
      check("t2 seq", 32'(issue_tid), 32'(seq2[i]));
    end

    // 3: halt thread 2 then thread 0; the pipeline drains to idle after WB_LAT edges.
    do_reset();
    step("t3", 4'b0101, 0, 0, 0);
    step("t3", '0, 1, 2, 0);
    check("t3 after halt2", 32'(issue_tid), 32'd0);
    step("t3", '0, 0, 0, 0);
    check("t3 only0", 32'(issue_tid), 32'd0);
    step("t3", '0, 1, 0, 0);
    check("t3 bubble", 32'(issue_valid), 32'd0);
    for (int i = 0; i < WB_LAT - 1; i++) step("t3 drain", '0, 0, 0, 0);
    check("t3 not idle yet", 32'(all_idle), 32'd0);
    step("t3 drain", '0, 0, 0, 0);
    check("t3 idle", 32'(all_idle), 32'd1);

    // 4: stall for two edges while thread 1 is in issue; no skip afterwards.
    do_reset();
    step("t4", 4'b1111, 0, 0, 0);
    step("t4", '0, 0, 0, 0);
    check("t4 pre", 32'(issue_tid), 32'd1);
    step("t4 stall", '0, 0, 0, 1);
    step("t4 stall", '0, 0, 0, 1);
    check("t4 hold", 32'(issue_tid), 32'd1);
    step("t4", '0, 0, 0, 0);
    check("t4 next", 32'(issue_tid), 32'd2);

    // 5: issue-to-writeback alignment, and start+halt of the same thread together.
    do_reset();
    step("t5", 4'b1000, 0, 0, 0);
    check("t5 issue3", 32'(issue_tid), 32'd3);
    step("t5", 4'b0010, 1, 1, 0);
    check("t5 start+halt", 32'(active_mask[1]), 32'd0);
    step("t5", '0, 0, 0, 0);
    check("t5 wb early", 32'(wb_valid), 32'd0);
    step("t5", '0, 0, 0, 0);
    check("t5 wb_valid", 32'(wb_valid), 32'd1);
    check("t5 wb_tid", 32'(wb_tid), 32'd3);

    // 6: asynchronous reset mid-stream, then a lone thread 3 restart.
    do_reset();
    step("t6", 4'b1111, 0, 0, 0);
    for (int i = 0; i < WB_LAT + 1; i++) step("t6 fill", '0, 0, 0, 0);
    check("t6 full", 32'(wb_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("t6 async issue_valid", 32'(issue_valid), 32'd0);
    check("t6 async issue_tid", 32'(issue_tid), 32'd0);
    check("t6 async wb_valid", 32'(wb_valid), 32'd0);
    check("t6 async wb_tid", 32'(wb_tid), 32'd0);
    check("t6 async mask", 32'(active_mask), 32'd0);
    check("t6 async idle", 32'(all_idle), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("t6 reset");
    step("t6", 4'b1000, 0, 0, 0);
    check("t6 restart", 32'(issue_tid), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step("t6", '0, 0, 0, 0);
      check("t6 lone", 32'(issue_tid), 32'd3);
    end

    // Random traffic: sparse starts, occasional halts and stalls.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] st;
      bit           hv;
      bit           sl;
      int           ht;
      st = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      hv = ($urandom_range(0, 6) == 0);
      ht = $urandom_range(0, N - 1);
      sl = ($urandom_range(0, 4) == 0);
      step("rand", st, hv, ht, sl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_thread_scheduler
